// File: rtl/uart_pkg.sv
// uart_pkg: baud divisors, byte FSM encoding and mid-bit sample tick shared by the UART blocks.
package uart_pkg;
  localparam logic [8:0] DIV_9600   = 9'd326;
  localparam logic [8:0] DIV_19200  = 9'd163;
  localparam logic [8:0] DIV_38400  = 9'd81;
  localparam logic [8:0] DIV_57600  = 9'd54;
  localparam logic [8:0] DIV_115200 = 9'd27;
  localparam logic [3:0] SAMPLE_TICK = 4'd7;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  function automatic logic [8:0] baud_div(input logic [2:0] sel);
    return sel == 3'd1 ? DIV_19200 :
           sel == 3'd2 ? DIV_38400 :
           sel == 3'd3 ? DIV_57600 :
           sel == 3'd4 ? DIV_115200 : DIV_9600;
  endfunction
endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: synchronizer, start detect, 16x oversampling and 8N1 byte FSM.
// UART_RX_TIMEOUT_EN exposes the oversample tick for the word-level idle timeout.
module uart_byte_rx
  import uart_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [2:0] Baud_Set,
  input  logic       uart_rx,
`ifdef UART_RX_TIMEOUT_EN
  output logic       tick,
`endif
  output logic [7:0] byte_data,
  output logic       byte_done,
  output logic       byte_err,
  output logic       busy
);
  logic s1, s2, prev, fall, sample;
  logic [2:0] baud_r, bit_cnt;
  logic [8:0] div_cnt;
  logic [3:0] tick_cnt;
  logic [7:0] sh;
  rx_state_t st;
`ifndef UART_RX_TIMEOUT_EN
  logic tick;
`endif
  assign fall = prev & ~s2;
  assign tick = div_cnt == baud_div(baud_r) - 9'd1;
  assign sample = st != IDLE && tick && tick_cnt == SAMPLE_TICK;
  assign byte_done = sample && st == STOP && s2;
  assign byte_err = sample && st == STOP && !s2;
  assign byte_data = sh;
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
      st <= IDLE;
      busy <= 1'b0;
      baud_r <= 3'd0;
      div_cnt <= 9'd0;
      tick_cnt <= 4'd0;
      bit_cnt <= 3'd0;
      sh <= 8'd0;
    end else begin
      s1 <= uart_rx;
      s2 <= s1;
      prev <= s2;
      div_cnt <= tick ? 9'd0 : div_cnt + 9'd1;
      if (tick) tick_cnt <= tick_cnt + 4'd1;
      case (st)
        IDLE: if (fall) begin
          st <= START;
          busy <= 1'b1;
          baud_r <= Baud_Set;
          div_cnt <= 9'd0;
          tick_cnt <= 4'd0;
        end
        START: if (sample) begin
          st <= s2 ? IDLE : DATA;
          busy <= ~s2;
          bit_cnt <= 3'd0;
        end
        DATA: if (sample) begin
          sh <= {s2, sh[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) st <= STOP;
        end
        STOP: if (sample) begin
          st <= IDLE;
          busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_data_rx.sv
// uart_data_rx: assembles DATA_WIDTH/8 UART bytes into a word with a one-cycle Rx_Done.
// UART_RX_TIMEOUT_EN drops a partial word after TIMEOUT_BITS idle bit-times.
module uart_data_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 56,
  parameter int MSB_FIRST    = 1,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [2:0]            Baud_Set,
  input  logic                  uart_rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  Rx_Done,
  output logic                  Frame_Err,
  output logic                  uart_state
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(NB + 1);
  logic [7:0] byte_data;
  logic byte_done, byte_err, last;
  logic [CW-1:0] cnt, idx;
  logic [DATA_WIDTH-1:0] shadow, nxt;
`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_BITS * 16 + 1);
  logic tick;
  logic [TW-1:0] idle;
`endif
  uart_byte_rx u_byte (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Baud_Set(Baud_Set),
    .uart_rx(uart_rx),
`ifdef UART_RX_TIMEOUT_EN
    .tick(tick),
`endif
    .byte_data(byte_data),
    .byte_done(byte_done),
    .byte_err(byte_err),
    .busy(uart_state)
  );
  assign last = cnt == CW'(NB - 1);
  assign idx = MSB_FIRST != 0 ? CW'(NB - 1) - cnt : cnt;
  always_comb begin
    nxt = shadow;
    nxt[{idx, 3'b000} +: 8] = byte_data;
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      data <= '0;
      shadow <= '0;
      cnt <= '0;
      Rx_Done <= 1'b0;
      Frame_Err <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      idle <= '0;
`endif
    end else begin
      Rx_Done <= byte_done && last;
      Frame_Err <= byte_err;
`ifdef UART_RX_TIMEOUT_EN
      if (uart_state || cnt == '0) idle <= '0;
      else if (tick) idle <= idle + 1'b1;
      if (!uart_state && cnt != '0 && tick && idle == TW'(TIMEOUT_BITS * 16 - 1)) cnt <= '0;
`endif
      if (byte_err) cnt <= '0;
      else if (byte_done) begin
        shadow <= nxt;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) data <= nxt;
      end
    end
  end
endmodule

// File: tb/tb_uart_data_rx.sv
// tb_uart_data_rx: randomized 8N1 frames checked against a queue-based word model.
module tb_uart_data_rx;
  localparam int DW = 56;
  localparam int NB = DW / 8;
  localparam int MSB = 1;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic [2:0] Baud_Set = 3'd4;
  logic uart_rx = 1'b1;
  logic [DW-1:0] data;
  logic Rx_Done, Frame_Err, uart_state;
  int total = 0, bad = 0;
  logic [DW-1:0] exp_q[$];
  int exp_err = 0;
  logic [DW-1:0] acc = '0;
  int acc_n = 0;
  logic [DW-1:0] last_data = '0, last_rx = '0;
  bit rst_pulse = 1'b0;

  always #5 Clk = ~Clk;

  uart_data_rx #(.DATA_WIDTH(DW), .MSB_FIRST(MSB), .TIMEOUT_BITS(20)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Baud_Set(Baud_Set), .uart_rx(uart_rx),
    .data(data), .Rx_Done(Rx_Done), .Frame_Err(Frame_Err), .uart_state(uart_state)
  );

  function automatic int div_of(input logic [2:0] b);
    case (b)
      3'd1: return 163;
      3'd2: return 81;
      3'd3: return 54;
      3'd4: return 27;
      default: return 326;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge Clk);
    #1;
  endtask

  function automatic void model_clear();
    acc = '0;
    acc_n = 0;
  endfunction

  always @(negedge Clk) begin
    if (rst_pulse) last_data = data;
    else begin
      if (Rx_Done) begin
        if (exp_q.size() == 0) check("unexpected_rx_done", 64'd1, 64'd0);
        else check("rx_word", 64'(data), 64'(exp_q.pop_front()));
        last_data = data;
        last_rx = data;
      end else if (data !== last_data) check("data_hold", 64'(data), 64'(last_data));
      if (Frame_Err) begin
        if (exp_err == 0) check("unexpected_frame_err", 64'd1, 64'd0);
        else begin
          exp_err--;
          total++;
        end
      end
      if (Rx_Done && Frame_Err) check("done_err_exclusive", 64'd1, 64'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit ok);
    int n;
    bit word_end;
    n = div_of(Baud_Set) * 16;
    word_end = 1'b0;
    uart_rx = 1'b0;
    step(n);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      if (i == 3) begin
        step(n / 2);
        check("busy_mid_byte", 64'(uart_state), 64'd1);
        step(n - n / 2);
      end else step(n);
    end
    if (ok) begin
      acc = MSB != 0 ? (acc << 8) | DW'(b) : acc | (DW'(b) << (8 * acc_n));
      acc_n++;
      if (acc_n == NB) begin
        exp_q.push_back(acc);
        word_end = 1'b1;
        model_clear();
      end
    end else begin
      exp_err++;
      model_clear();
    end
    uart_rx = ok;
    step(n * 12 / 16);
    uart_rx = 1'b1;
    step($urandom_range(0, 20));
    if (word_end) check("rx_done_seen", 64'(exp_q.size()), 64'd0);
    if (!ok) check("frame_err_seen", 64'(exp_err), 64'd0);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = NB - 1; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  initial begin
    step(5);
    check("rst_data", 64'(data), 64'd0);
    check("rst_done", 64'(Rx_Done), 64'd0);
    check("rst_ferr", 64'(Frame_Err), 64'd0);
    check("rst_state", 64'(uart_state), 64'd0);
    Rst_n = 1'b1;
    step(5);
    // 4-tick glitch at 9600 must be rejected at the start-bit sample
    Baud_Set = 3'd0;
    uart_rx = 1'b0;
    step(2 * 326);
    check("glitch_busy", 64'(uart_state), 64'd1);
    step(2 * 326);
    uart_rx = 1'b1;
    step(2 * 326);
    check("glitch_busy_late", 64'(uart_state), 64'd1);
    step(4 * 326);
    check("glitch_idle", 64'(uart_state), 64'd0);
    Baud_Set = 3'd4;
    step(10);
`ifdef UART_RX_TIMEOUT_EN
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    step(25 * 16 * 27);
    model_clear();
    send_word(56'h11223344556677);
    check("timeout_word", 64'(last_rx), 64'h0011223344556677);
`else
    send_word(56'h01234567012345);
    check("msb_word", 64'(last_rx), 64'h0001234567012345);
    check("msb_data", 64'(data), 64'h0001234567012345);
`endif
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    check("ferr_data_kept", 64'(data), 64'(last_rx));
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    rst_pulse = 1'b1;
    Rst_n = 1'b0;
    step(1);
    Rst_n = 1'b1;
    model_clear();
    check("midrst_data", 64'(data), 64'd0);
    check("midrst_state", 64'(uart_state), 64'd0);
    check("midrst_done", 64'(Rx_Done), 64'd0);
    step(2);
    rst_pulse = 1'b0;
    send_word(56'hAABBCCDDEEFF11);
    check("clean_word", 64'(last_rx), 64'h00AABBCCDDEEFF11);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("err_empty", 64'(exp_err), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (200000) @(posedge Clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_data_rx.md
# uart_data_rx

Multi-byte UART receiver: the receive-side counterpart of `uart_data_tx`. It oversamples the serial line `uart_rx` at 16× the selected baud rate and recovers 8N1 bytes. It then assembles DATA_WIDTH/8 consecutive bytes into one word and presents that word with a single-cycle `Rx_Done` strobe. Byte order matches the transmitter so the two blocks form a loopback pair.

## Interface
- `DATA_WIDTH`, 56: assembled word width; must be a multiple of 8, range 8..64.
- `MSB_FIRST`, 1: 1 = first received byte lands in `data[DATA_WIDTH-1 -: 8]`; 0 = first byte lands in `data[7:0]`.
- `TIMEOUT_BITS`, 20: inter-byte idle limit in bit-times; used only when `UART_RX_TIMEOUT_EN` is defined.
- `Clk` in 1: system clock, 50 MHz. One clock; reset is synchronous and active-low.
- `Rst_n` in 1: synchronous active-low reset.
- `Baud_Set` in 3: baud rate select.
  - 0 = 9600, 1 = 19200, 2 = 38400, 3 = 57600, 4 = 115200.
  - 5..7 behave as 9600.
- `uart_rx` in 1: asynchronous serial input; idles high.
- `data` out DATA_WIDTH: last complete word; holds its value until the next word completes.
- `Rx_Done` out 1: one-cycle pulse, word valid on `data`.
- `Frame_Err` out 1: one-cycle pulse, stop bit sampled low.
- `uart_state` out 1: high from start-edge detection until the byte FSM returns to IDLE.

## Operation
- `uart_rx` passes through a 2-FF synchronizer, then a 1-cycle delay register. A falling edge is `prev=1 && cur=0`.
- Oversample tick divisor (`Clk` cycles per tick, counter runs 0..N-1):
  - 9600: 326
  - 19200: 163
  - 38400: 81
  - 57600: 54
  - 115200: 27
- `Baud_Set` is latched on the start edge. Changes during a byte take effect at the next start edge.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on falling edge. Tick counter clears and `uart_state` rises.
  - START: at tick 7 the line is sampled. If high (glitch), go to IDLE with no output. If low, go to DATA.
  - DATA: eight bits, LSB first, each sampled at tick 7 of its 16-tick bit.
  - STOP: sampled at tick 7 of the stop bit.
    - High: the byte is accepted.
    - Low: `Frame_Err` pulses, the byte is discarded, and the byte counter clears (partial word dropped).
  - After the stop-bit sample, go to IDLE.
- Word assembly:
  - Each accepted byte is written into a shadow register at the position given by the byte counter and `MSB_FIRST`; the counter then increments.
  - When the counter reaches DATA_WIDTH/8, the shadow is copied to `data`, `Rx_Done` pulses and the counter wraps to 0.
- A new start edge is accepted in the cycle after the return to IDLE. The remaining half stop bit is not waited for, so back-to-back transmitter output is received.

## Timing
- Reset values: `data`=0, `Rx_Done`=0, `Frame_Err`=0, `uart_state`=0; FSM in IDLE; byte counter 0; synchronizer registers 1.
- Reset mid-byte or mid-word aborts everything. The next word starts from byte 0.
- Start-edge detection latency: 3 `Clk` cycles after the line falls (2 sync + edge register).
- `Rx_Done` asserts in the `Clk` cycle after the last byte's stop-bit sample. `data` changes in that same cycle.
- `Rx_Done` and `Frame_Err` are mutually exclusive.
- `uart_state` falls in the same cycle as `Rx_Done` or `Frame_Err`, or when a START glitch is rejected.
- A line held low (break) produces `Frame_Err` once. No new start is detected until the line has been seen high and then falls again.

## Configuration
- Macro: `UART_RX_TIMEOUT_EN`.
- Defined:
  - An idle counter runs while the FSM is in IDLE with byte counter ≠ 0.
  - When it reaches `TIMEOUT_BITS`×16 ticks, the byte counter clears silently: no pulse, and `data` is unchanged.
  - The idle counter resets on every start edge.
- Undefined:
  - No idle counter.
  - A partial word waits indefinitely for its remaining bytes.

## Structure
- Package `uart_pkg`: baud divisor constants, the FSM state encoding and the tick-sample constant (7). It is shared with `uart_data_tx`.
- Sub-module `uart_byte_rx`: synchronizer, start detect, oversampling and the byte FSM. It outputs `byte_data[7:0]`, `byte_done` and `byte_err`.
- Top `uart_data_rx`: byte counter, shadow register, output register and optional timeout.

## Test plan
1. **MSB-first word.** `Baud_Set`=4, `MSB_FIRST`=1; drive 7 frames carrying bytes 01 23 45 67 01 23 45. Expect exactly one `Rx_Done` pulse, after the 7th stop-bit sample, with `data`=56'h01234567012345.
2. **Loopback.** Drive `uart_data_tx` with 56'h12345678123456 and then 56'h23456789234567 back-to-back (`Baud_Set`=4). Expect two `Rx_Done` pulses with matching `data`; `Frame_Err` never asserts.
3. **Frame error.** Force the stop bit low on byte 3 of a word. Expect a `Frame_Err` pulse and no `Rx_Done`. A following clean 56'hAABBCCDDEEFF11 word is then received correctly.
4. **Glitch rejection.** 4-tick low pulse on `uart_rx` at 9600 baud. Expect no pulses, and `uart_state` returns to 0 at tick 7.
5. **Reset mid-word.** `Rst_n`=0 for 1 cycle after byte 2. Expect all outputs 0. The next full 7-byte word is assembled from byte 0.
6. **Timeout (`UART_RX_TIMEOUT_EN` defined).** Send 3 bytes, idle for 25 bit-times, then send 7 bytes 11..77. Expect `data`=56'h11223344556677. With the macro undefined, expect the first word to complete early from the 3+4 bytes.
